id_operand_unit: RTL and testbench
==================================

// Module: id_operand_unit
// PURPOSE
// - Parametrised ID-stage operand unit: register file, N-port read, forwarding from NFWD pipeline stages, hazard stall generation.
// - Generalises the fixed 2-read, EX/MEM/WB bypass path in several ways:
//   - configurable XLEN, register count, read ports and forward sources;
//   - per-source data-ready flags (loads, late results);
//   - a pending-write scoreboard for long-latency writers (divider, miss returns);
//   - a saturating hazard-stall counter.
// - Sits between IF/ID register and ID/EX register; stall_o feeds hazard unit.
// PARAMETERS
// XLEN      32  data width
// NREG      32  architectural registers; AW = $clog2(NREG)
// NRD       2   read ports
// NFWD      3   forward sources; index 0 = youngest (EX), highest priority
// ZERO_REG  1   1: register 0 reads 0, writes ignored, never pending
// CNT_W     32  stall counter width
// PORTS
// clk_i          in   1          clock, rising edge
// rst_i          in   1          asynchronous reset, active-low
// id_valid_i     in   1          ID holds a valid instruction
// id_stall_i     in   1          external stall of ID (from hazard/flush logic)
// rd_use_i       in   NRD        port p operand needed this cycle
// rd_addr_i      in   NRD*AW     read addresses, port p at [p*AW +: AW]
// fwd_we_i       in   NFWD       source s will write a register
// fwd_waddr_i    in   NFWD*AW    source s destination
// fwd_ready_i    in   NFWD       source s data valid this cycle
// fwd_wdata_i    in   NFWD*XLEN  source s result
// wb_we_i        in   1          regfile write enable
// wb_waddr_i     in   AW         regfile write address
// wb_wdata_i     in   XLEN       regfile write data
// wb_lat_i       in   1          this write retires a long-latency op (clears pending)
// lat_set_i      in   1          long-latency op for lat_addr_i leaves ID this cycle
// lat_addr_i     in   AW         its destination register
// rdata_o        out  NRD*XLEN   resolved operands, port p at [p*XLEN +: XLEN]
// stall_o        out  1          operand hazard: ID must hold
// pending_o      out  NREG       scoreboard bits (debug/verification)
// stall_cnt_o    out  CNT_W      cycles with id_valid_i & stall_o
// BEHAVIOUR
// - Reset (rst_i=0, async): all registers 0, pending_o=0, stall_cnt_o=0. rdata_o and stall_o are combinational.
// - Regfile write at posedge when wb_we_i (and not reg 0 if ZERO_REG).
// - Operand resolution per port p, combinational, first hit wins:
//   1. ZERO_REG & addr==0 -> 0.
//   2. Lowest s with fwd_we_i[s] & fwd_waddr==addr -> fwd_wdata_i[s]; hit with fwd_ready_i[s]=0 = unready hit.
//   3. wb_we_i & wb_waddr==addr -> wb_wdata_i (write-through bypass).
//   4. Otherwise the regfile content.
// - Port hazard h[p] = rd_use_i[p] & (unready hit | (pending[addr] & no ready fwd hit at step 2)).
// - stall_o = id_valid_i & |h. Ports with rd_use_i=0 never stall.
// - Scoreboard, per register r, at posedge:
//   - set when lat_set_i & lat_addr_i==r & !stall_o & !id_stall_i;
//   - cleared when wb_we_i & wb_lat_i & wb_waddr_i==r;
//   - set and clear of the same r in the same cycle -> set wins.
//   - r==0 never set when ZERO_REG.
// - stall_cnt_o increments by 1 per cycle with id_valid_i & stall_o, saturates at all-ones, no wrap.
// - Reset mid-stall clears pending bits immediately; no stall after reset release until new sets.
// - Latency: regfile write visible to step-4 reads the cycle after the write; same-cycle visibility via step 3.
// TESTING
// - Reset, write R5=0x1234_5678 via WB, read port0 next cycle -> 0x12345678, stall_o=0.
// - Read R3 with EX(s0)=0xAAAA0000 ready and MEM(s1)=0xBBBB0000 both writing R3 -> 0xAAAA0000 (youngest wins).
// - EX writes R7 with fwd_ready=0, rd_use[1]=1, rd_addr1=7 -> stall_o=1; MEM ready next cycle -> stall_o=0, data from MEM.
// - lat_set R9; read R9 -> stall_o=1 for each cycle; WB R9 with wb_lat=1, data 0x55 -> same-cycle read 0x55, stall_o=0, pending[9]=0 next cycle.
// - Same cycle: lat_set R4 and WB clear of R4 -> pending[4]=1; write R0=0xFFFF -> read 0; rd_use=0 on pending reg -> no stall.
// - Force CNT_W=4, hold a stall for 20 cycles -> stall_cnt_o stops at 15; assert rst_i=0 -> counter and pending cleared asynchronously.

Source files
------------

// File: rtl/id_operand_if.sv
// Bundle of the ID-stage operand unit signals.
// slave  : seen by id_operand_unit (operand requests, forward sources,
//          writeback, long-latency issue in; operands, stall, debug out).
// master : seen by whoever drives the unit (testbench or decode stage).
// Handshake: there is no valid/ready pair on this bundle. id_valid_i marks a
// live instruction; stall_o is a combinational hold request the decode stage
// must honour in the same cycle. A long-latency issue (lat_set_i) only takes
// effect in a cycle where ID is not held (stall_o=0 and id_stall_i=0).
interface id_operand_if #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int NRD   = 2,
   parameter int NFWD  = 3,
   parameter int CNT_W = 32
);
   localparam int AW = $clog2(NREG);

   logic                 id_valid_i;
   logic                 id_stall_i;
   logic [NRD-1:0]       rd_use_i;
   logic [NRD*AW-1:0]    rd_addr_i;
   logic [NFWD-1:0]      fwd_we_i;
   logic [NFWD*AW-1:0]   fwd_waddr_i;
   logic [NFWD-1:0]      fwd_ready_i;
   logic [NFWD*XLEN-1:0] fwd_wdata_i;
   logic                 wb_we_i;
   logic [AW-1:0]        wb_waddr_i;
   logic [XLEN-1:0]      wb_wdata_i;
   logic                 wb_lat_i;
   logic                 lat_set_i;
   logic [AW-1:0]        lat_addr_i;
   logic [NRD*XLEN-1:0]  rdata_o;
   logic                 stall_o;
   logic [NREG-1:0]      pending_o;
   logic [CNT_W-1:0]     stall_cnt_o;

   modport slave (
      input  id_valid_i, id_stall_i, rd_use_i, rd_addr_i,
      input  fwd_we_i, fwd_waddr_i, fwd_ready_i, fwd_wdata_i,
      input  wb_we_i, wb_waddr_i, wb_wdata_i, wb_lat_i,
      input  lat_set_i, lat_addr_i,
      output rdata_o, stall_o, pending_o, stall_cnt_o
   );

   modport master (
      output id_valid_i, id_stall_i, rd_use_i, rd_addr_i,
      output fwd_we_i, fwd_waddr_i, fwd_ready_i, fwd_wdata_i,
      output wb_we_i, wb_waddr_i, wb_wdata_i, wb_lat_i,
      output lat_set_i, lat_addr_i,
      input  rdata_o, stall_o, pending_o, stall_cnt_o
   );
endinterface

// File: rtl/id_operand_unit.sv
// ID-stage operand unit: register file, NRD read ports with forwarding from
// NFWD pipeline stages (index 0 youngest, highest priority), writeback
// write-through, a pending-write scoreboard for long-latency writers and a
// saturating count of stalled cycles.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active low
//   bus    - id_operand_if.slave (operand requests, forward sources,
//            writeback, long-latency issue; operands, stall_o, pending_o,
//            stall_cnt_o)
module id_operand_unit #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int NRD      = 2,
   parameter int NFWD     = 3,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   id_operand_if.slave  bus
);
   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0]         r_regs [NREG];
   logic [NREG-1:0]         r_pending;
   logic [CNT_W-1:0]        r_stall_cnt;

   logic [NRD-1:0][AW-1:0]  w_addr;
   logic [NRD-1:0]          w_found;
   logic [NRD-1:0]          w_unready;
   logic [NRD-1:0]          w_ready_hit;
   logic [NRD-1:0]          w_hazard;
   logic [NRD*XLEN-1:0]     w_rdata;
   logic                    w_stall;

   // Operand resolution: zero register, then youngest matching forward
   // source, then writeback write-through, then the register file.
   always_comb begin
      w_addr      = '0;
      w_found     = '0;
      w_unready   = '0;
      w_ready_hit = '0;
      w_hazard    = '0;
      w_rdata     = '0;
      for (int p = 0; p < NRD; p++) begin
         w_addr[p] = bus.rd_addr_i[p*AW +: AW];
         w_rdata[p*XLEN +: XLEN] = r_regs[w_addr[p]];
         if (ZERO_REG != 0 && w_addr[p] == '0) begin
            w_rdata[p*XLEN +: XLEN] = '0;
         end else begin
            for (int s = 0; s < NFWD; s++) begin
               if (!w_found[p] && bus.fwd_we_i[s] &&
                   bus.fwd_waddr_i[s*AW +: AW] == w_addr[p]) begin
                  w_found[p]     = 1'b1;
                  w_unready[p]   = ~bus.fwd_ready_i[s];
                  w_ready_hit[p] = bus.fwd_ready_i[s];
                  w_rdata[p*XLEN +: XLEN] = bus.fwd_wdata_i[s*XLEN +: XLEN];
               end
            end
            if (!w_found[p] && bus.wb_we_i && bus.wb_waddr_i == w_addr[p]) begin
               w_rdata[p*XLEN +: XLEN] = bus.wb_wdata_i;
            end
         end
         // A ready forward hit supplies the value even while the register is
         // still marked pending; the zero register is never pending.
         w_hazard[p] = bus.rd_use_i[p] &
                       (w_unready[p] | (r_pending[w_addr[p]] & ~w_ready_hit[p]));
      end
   end

   assign w_stall         = bus.id_valid_i & (|w_hazard);
   assign bus.rdata_o     = w_rdata;
   assign bus.stall_o     = w_stall;
   assign bus.pending_o   = r_pending;
   assign bus.stall_cnt_o = r_stall_cnt;

   // Register file
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int r = 0; r < NREG; r++) begin
            r_regs[r] <= '0;
         end
      end else if (bus.wb_we_i && !(ZERO_REG != 0 && bus.wb_waddr_i == '0)) begin
         r_regs[bus.wb_waddr_i] <= bus.wb_wdata_i;
      end
   end

   // Scoreboard: a long-latency issue only counts when ID actually advances;
   // a set in the same cycle as a retire of the same register wins.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_pending <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (bus.lat_set_i && bus.lat_addr_i == AW'(r) && !w_stall &&
                !bus.id_stall_i && !(ZERO_REG != 0 && r == 0)) begin
               r_pending[r] <= 1'b1;
            end else if (bus.wb_we_i && bus.wb_lat_i && bus.wb_waddr_i == AW'(r)) begin
               r_pending[r] <= 1'b0;
            end
         end
      end
   end

   // Saturating stall counter
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_stall_cnt <= '0;
      end else if (bus.id_valid_i && w_stall && r_stall_cnt != '1) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_id_operand_unit.sv
module tb_id_operand_unit;
   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int NRD   = 2;
   localparam int NFWD  = 3;
   localparam int CNT_W = 4;
   localparam int AW    = 5;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   // reference state
   logic [XLEN-1:0] m_regs [NREG];
   logic [NREG-1:0] m_pending;
   int              m_cnt;
   logic [XLEN-1:0] exp_rdata [NRD];
   logic            exp_stall;

   id_operand_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD), .CNT_W(CNT_W)) bus ();

   id_operand_unit #(
      .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD), .ZERO_REG(1), .CNT_W(CNT_W)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      bus.id_valid_i  = 1'b0;
      bus.id_stall_i  = 1'b0;
      bus.rd_use_i    = '0;
      bus.rd_addr_i   = '0;
      bus.fwd_we_i    = '0;
      bus.fwd_waddr_i = '0;
      bus.fwd_ready_i = '0;
      bus.fwd_wdata_i = '0;
      bus.wb_we_i     = 1'b0;
      bus.wb_waddr_i  = '0;
      bus.wb_wdata_i  = '0;
      bus.wb_lat_i    = 1'b0;
      bus.lat_set_i   = 1'b0;
      bus.lat_addr_i  = '0;
   endtask

   task automatic set_read(input int p, input logic use_it, input logic [AW-1:0] a);
      bus.rd_use_i[p] = use_it;
      bus.rd_addr_i[p*AW +: AW] = a;
   endtask

   task automatic set_fwd(input int s, input logic we, input logic [AW-1:0] a,
                          input logic rdy, input logic [XLEN-1:0] d);
      bus.fwd_we_i[s] = we;
      bus.fwd_waddr_i[s*AW +: AW] = a;
      bus.fwd_ready_i[s] = rdy;
      bus.fwd_wdata_i[s*XLEN +: XLEN] = d;
   endtask

   task automatic set_wb(input logic we, input logic [AW-1:0] a,
                         input logic [XLEN-1:0] d, input logic lat);
      bus.wb_we_i    = we;
      bus.wb_waddr_i = a;
      bus.wb_wdata_i = d;
      bus.wb_lat_i   = lat;
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREG; r++) m_regs[r] = '0;
      m_pending = '0;
      m_cnt     = 0;
   endtask

   // Reference: operand value and hazard, straight from the resolution rules.
   task automatic model_eval();
      logic any_h;
      any_h = 1'b0;
      for (int p = 0; p < NRD; p++) begin
         int a;
         int hit;
         logic h;
         a   = int'(bus.rd_addr_i[p*AW +: AW]);
         hit = -1;
         h   = 1'b0;
         if (a == 0) begin
            exp_rdata[p] = '0;
         end else begin
            for (int s = NFWD - 1; s >= 0; s--)
               if (bus.fwd_we_i[s] && int'(bus.fwd_waddr_i[s*AW +: AW]) == a) hit = s;
            if (hit >= 0)
               exp_rdata[p] = bus.fwd_wdata_i[hit*XLEN +: XLEN];
            else if (bus.wb_we_i && int'(bus.wb_waddr_i) == a)
               exp_rdata[p] = bus.wb_wdata_i;
            else
               exp_rdata[p] = m_regs[a];
            if (hit >= 0 && !bus.fwd_ready_i[hit]) h = 1'b1;
            if (m_pending[a] && !(hit >= 0 && bus.fwd_ready_i[hit])) h = 1'b1;
         end
         if (bus.rd_use_i[p] && h) any_h = 1'b1;
      end
      exp_stall = bus.id_valid_i & any_h;
   endtask

   // Advance one clock and move the reference state along with it.
   task automatic tick();
      model_eval();
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (bus.wb_we_i && bus.wb_waddr_i != 0) m_regs[bus.wb_waddr_i] = bus.wb_wdata_i;
         if (bus.wb_we_i && bus.wb_lat_i) m_pending[bus.wb_waddr_i] = 1'b0;
         if (bus.lat_set_i && !exp_stall && !bus.id_stall_i && bus.lat_addr_i != 0)
            m_pending[bus.lat_addr_i] = 1'b1;
         if (bus.id_valid_i && exp_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      tick();
      tick();
      bus.id_valid_i = 1'b1;
      set_read(0, 1'b1, 5'd5);
      #2;
      checks++;
      if (bus.pending_o !== '0) begin
         errors++; $display("FAIL reset_pending got=%h want=0", bus.pending_o);
      end
      checks++;
      if (bus.stall_cnt_o !== '0) begin
         errors++; $display("FAIL reset_cnt got=%0d want=0", bus.stall_cnt_o);
      end
      checks++;
      if (bus.rdata_o[31:0] !== 32'h0 || bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL reset_read got=%h stall=%b want=0 stall=0", bus.rdata_o[31:0], bus.stall_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_inputs();
   endtask

   task automatic test_wb_write();
      set_wb(1'b1, 5'd5, 32'h1234_5678, 1'b0);
      tick();
      clear_inputs();
      bus.id_valid_i = 1'b1;
      set_read(0, 1'b1, 5'd5);
      #2;
      checks++;
      if (bus.rdata_o[31:0] !== 32'h1234_5678 || bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL wb_write_read got=%h stall=%b want=12345678 stall=0", bus.rdata_o[31:0], bus.stall_o);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_fwd_priority();
      bus.id_valid_i = 1'b1;
      set_read(0, 1'b1, 5'd3);
      set_fwd(0, 1'b1, 5'd3, 1'b1, 32'hAAAA_0000);
      set_fwd(1, 1'b1, 5'd3, 1'b1, 32'hBBBB_0000);
      set_fwd(2, 1'b1, 5'd3, 1'b1, 32'hCCCC_0000);
      #2;
      checks++;
      if (bus.rdata_o[31:0] !== 32'hAAAA_0000 || bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL fwd_priority got=%h want=aaaa0000", bus.rdata_o[31:0]);
      end
      set_fwd(0, 1'b0, 5'd0, 1'b0, 32'h0);
      #1;
      checks++;
      if (bus.rdata_o[31:0] !== 32'hBBBB_0000) begin
         errors++; $display("FAIL fwd_mem got=%h want=bbbb0000", bus.rdata_o[31:0]);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_unready();
      bus.id_valid_i = 1'b1;
      set_read(1, 1'b1, 5'd7);
      set_fwd(0, 1'b1, 5'd7, 1'b0, 32'hDEAD_0007);
      #2;
      checks++;
      if (bus.stall_o !== 1'b1) begin
         errors++; $display("FAIL unready_stall got=%b want=1", bus.stall_o);
      end
      tick();
      checks++;
      if (bus.stall_cnt_o !== 4'd1) begin
         errors++; $display("FAIL unready_cnt got=%0d want=1", bus.stall_cnt_o);
      end
      set_fwd(0, 1'b0, 5'd0, 1'b0, 32'h0);
      set_fwd(1, 1'b1, 5'd7, 1'b1, 32'hCAFE_0007);
      #2;
      checks++;
      if (bus.stall_o !== 1'b0 || bus.rdata_o[63:32] !== 32'hCAFE_0007) begin
         errors++; $display("FAIL unready_mem got=%h stall=%b want=cafe0007 stall=0", bus.rdata_o[63:32], bus.stall_o);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_pending();
      bus.id_valid_i = 1'b1;
      bus.lat_set_i  = 1'b1;
      bus.lat_addr_i = 5'd9;
      tick();
      clear_inputs();
      checks++;
      if (bus.pending_o[9] !== 1'b1) begin
         errors++; $display("FAIL pending_set got=%b want=1", bus.pending_o[9]);
      end
      bus.id_valid_i = 1'b1;
      set_read(0, 1'b1, 5'd9);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.stall_o !== 1'b1) begin
            errors++; $display("FAIL pending_stall cycle=%0d got=%b want=1", i, bus.stall_o);
         end
         tick();
      end
      checks++;
      if (bus.stall_cnt_o !== 4'd4) begin
         errors++; $display("FAIL pending_cnt got=%0d want=4", bus.stall_cnt_o);
      end
      // The retiring writeback is also the oldest forward source.
      set_wb(1'b1, 5'd9, 32'h55, 1'b1);
      set_fwd(2, 1'b1, 5'd9, 1'b1, 32'h55);
      #2;
      checks++;
      if (bus.rdata_o[31:0] !== 32'h55 || bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL pending_retire got=%h stall=%b want=55 stall=0", bus.rdata_o[31:0], bus.stall_o);
      end
      tick();
      clear_inputs();
      checks++;
      if (bus.pending_o[9] !== 1'b0) begin
         errors++; $display("FAIL pending_clear got=%b want=0", bus.pending_o[9]);
      end
   endtask

   task automatic test_set_clear_zero();
      bus.lat_set_i  = 1'b1;
      bus.lat_addr_i = 5'd4;
      tick();
      set_wb(1'b1, 5'd4, 32'h4444, 1'b1);
      tick();
      clear_inputs();
      checks++;
      if (bus.pending_o[4] !== 1'b1) begin
         errors++; $display("FAIL set_wins got=%b want=1", bus.pending_o[4]);
      end
      bus.id_valid_i = 1'b1;
      set_wb(1'b1, 5'd0, 32'hFFFF, 1'b0);
      set_fwd(0, 1'b1, 5'd0, 1'b0, 32'h1111);
      set_read(0, 1'b1, 5'd0);
      bus.lat_set_i  = 1'b1;
      bus.lat_addr_i = 5'd0;
      #2;
      checks++;
      if (bus.rdata_o[31:0] !== 32'h0 || bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL zero_same got=%h stall=%b want=0 stall=0", bus.rdata_o[31:0], bus.stall_o);
      end
      tick();
      clear_inputs();
      bus.id_valid_i = 1'b1;
      set_read(0, 1'b1, 5'd0);
      #2;
      checks++;
      if (bus.rdata_o[31:0] !== 32'h0 || bus.pending_o[0] !== 1'b0) begin
         errors++; $display("FAIL zero_next got=%h pend0=%b want=0 pend0=0", bus.rdata_o[31:0], bus.pending_o[0]);
      end
      set_read(0, 1'b0, 5'd4);
      set_read(1, 1'b0, 5'd4);
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL unused_port got=%b want=0", bus.stall_o);
      end
      set_read(1, 1'b1, 5'd4);
      #1;
      checks++;
      if (bus.stall_o !== 1'b1) begin
         errors++; $display("FAIL used_port got=%b want=1", bus.stall_o);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (bus.stall_cnt_o !== 4'd15) begin
         errors++; $display("FAIL cnt_saturate got=%0d want=15", bus.stall_cnt_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (bus.pending_o !== '0 || bus.stall_cnt_o !== '0 || bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL async_reset pend=%h cnt=%0d stall=%b want=0 0 0", bus.pending_o, bus.stall_cnt_o, bus.stall_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL post_reset_stall got=%b want=0", bus.stall_o);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.id_valid_i = ($urandom_range(0, 7) != 0);
         bus.id_stall_i = ($urandom_range(0, 3) == 0);
         for (int p = 0; p < NRD; p++)
            set_read(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
         for (int s = 0; s < NFWD; s++)
            set_fwd(s, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0), $urandom);
         set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)));
         bus.lat_set_i  = ($urandom_range(0, 3) == 0);
         bus.lat_addr_i = 5'($urandom_range(0, 7));
         #2;
         model_eval();
         for (int p = 0; p < NRD; p++) begin
            checks++;
            if (bus.rdata_o[p*XLEN +: XLEN] !== exp_rdata[p]) begin
               errors++; $display("FAIL rand_rdata%0d it=%0d got=%h want=%h", p, i, bus.rdata_o[p*XLEN +: XLEN], exp_rdata[p]);
            end
         end
         checks++;
         if (bus.stall_o !== exp_stall) begin
            errors++; $display("FAIL rand_stall it=%0d got=%b want=%b", i, bus.stall_o, exp_stall);
         end
         tick();
         checks++;
         if (bus.pending_o !== m_pending || int'(bus.stall_cnt_o) != m_cnt) begin
            errors++; $display("FAIL rand_state it=%0d pend=%h want=%h cnt=%0d want=%0d", i, bus.pending_o, m_pending, bus.stall_cnt_o, m_cnt);
         end
      end
      clear_inputs();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_wb_write();
      test_fwd_priority();
      test_unready();
      test_pending();
      test_set_clear_zero();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
